// File: rtl/lsu_lsq_alloc_ctrl_pkg.sv
// ============================================================================
// Module  : lsu_lsq_alloc_ctrl_pkg
// Brief   : Shared LSQ sizing constants, the wrap-bit pointer type and the
//           full/empty/occupancy helpers used by the LSQ and store-buffer
//           pointer controllers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_lsq_alloc_ctrl_pkg;

  localparam int unsigned LSQ_DEPTH = 8;
  localparam int unsigned LSQ_PTR_W = $clog2(LSQ_DEPTH);

  localparam int unsigned LSQ_ENTRY_NUM   = LSQ_DEPTH;
  localparam int unsigned LSQ_ENTRY_IDX_W = LSQ_PTR_W;
  localparam int unsigned LSQ_ENTRY_PTR_W = LSQ_PTR_W + 1;

  // Ring pointer: the extra wrap bit disambiguates full from empty.
  typedef struct packed {
    logic                 wrap;
    logic [LSQ_PTR_W-1:0] idx;
  } lsq_ptr_t;

  function automatic logic lsq_ptr_full(input lsq_ptr_t head, input lsq_ptr_t tail);
    return (head.idx == tail.idx) && (head.wrap != tail.wrap);
  endfunction

  function automatic logic lsq_ptr_empty(input lsq_ptr_t head, input lsq_ptr_t tail);
    return head == tail;
  endfunction

  // Modulo-2^(LSQ_PTR_W+1) difference is the occupancy.
  function automatic logic [LSQ_PTR_W:0] lsq_ptr_occ(input lsq_ptr_t head, input lsq_ptr_t tail);
    return tail - head;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lsq_alloc_ctrl_ring_ptr.sv
// ============================================================================
// Module  : lsu_ring_ptr
// Brief   : Single ring pointer with wrap bit; synchronous clear has priority
//           over increment. Power-of-two depth makes the index wrap natural.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_ring_ptr #(
  parameter int unsigned PTR_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           inc_i,
  output logic [PTR_W:0] ptr_o
);

  localparam logic [PTR_W:0] C_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0] ptr_q;
  logic [PTR_W:0] ptr_d;

  // Next pointer: clear wins, otherwise step by one when asked.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + C_ONE;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/lsu_lsq_alloc_ctrl.sv
// ============================================================================
// Module  : lsu_lsq_alloc_ctrl
// Brief   : LSQ ring-buffer pointer controller. Allocates the tail entry for
//           dispatched memory ops, retires the completed head on ROB commit,
//           and reports full/empty. No per-entry state is held here.
//           Optional perf counters: define LSU_LSQ_PERF_CNT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_lsq_alloc_ctrl
  import lsu_lsq_alloc_ctrl_pkg::*;
#(
  parameter int unsigned LSQ_DEPTH = lsu_lsq_alloc_ctrl_pkg::LSQ_DEPTH,
  parameter int unsigned LSQ_PTR_W = $clog2(LSQ_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 disp_vld_i,
  output logic                 disp_rdy_o,
  output logic [LSQ_DEPTH-1:0] alloc_onehot_o,
  output logic [LSQ_PTR_W-1:0] alloc_idx_o,
  input  logic [LSQ_DEPTH-1:0] entry_vld_i,
  input  logic [LSQ_DEPTH-1:0] entry_succ_i,
  input  logic [LSQ_DEPTH-1:0] entry_exc_i,
  input  logic                 rob_commit_i,
  output logic [LSQ_DEPTH-1:0] deq_onehot_o,
  output logic                 deq_vld_o,
  output logic                 deq_exc_o,
  output logic [LSQ_PTR_W-1:0] head_idx_o,
  output logic                 full_o,
  output logic                 empty_o
`ifdef LSU_LSQ_PERF_CNT_EN
  ,
  output logic [31:0]          perf_full_stall_o,
  output logic [LSQ_PTR_W:0]   perf_occ_max_o
`endif
);

  localparam logic [LSQ_DEPTH-1:0] C_ONEHOT0 = {{(LSQ_DEPTH-1){1'b0}}, 1'b1};

  logic [LSQ_PTR_W:0]   w_head_ptr;
  logic [LSQ_PTR_W:0]   w_tail_ptr;
  logic [LSQ_PTR_W-1:0] w_head_idx;
  logic [LSQ_PTR_W-1:0] w_tail_idx;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_clr;
  logic                 w_alloc_fire;
  logic                 w_deq_fire;

  assign w_clr      = rst | flush;
  assign w_head_idx = w_head_ptr[LSQ_PTR_W-1:0];
  assign w_tail_idx = w_tail_ptr[LSQ_PTR_W-1:0];

  // Full/empty derive purely from registered pointers, so dispatch readiness
  // never depends on a same-cycle dequeue.
  assign w_full  = (w_head_idx == w_tail_idx) & (w_head_ptr[LSQ_PTR_W] != w_tail_ptr[LSQ_PTR_W]);
  assign w_empty = (w_head_ptr == w_tail_ptr);

  // Strobes are gated off in the same cycle as reset/flush.
  assign w_alloc_fire = disp_vld_i & ~w_full & ~w_clr;
  assign w_deq_fire   = rob_commit_i & ~w_empty & entry_vld_i[w_head_idx]
                      & entry_succ_i[w_head_idx] & ~w_clr;

  lsu_ring_ptr #(.PTR_W(LSQ_PTR_W)) u_head_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .inc_i (w_deq_fire),
    .ptr_o (w_head_ptr)
  );

  lsu_ring_ptr #(.PTR_W(LSQ_PTR_W)) u_tail_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush),
    .inc_i (w_alloc_fire),
    .ptr_o (w_tail_ptr)
  );

  assign disp_rdy_o     = ~w_full;
  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign alloc_idx_o    = w_tail_idx;
  assign alloc_onehot_o = w_alloc_fire ? (C_ONEHOT0 << w_tail_idx) : '0;
  assign head_idx_o     = w_head_idx;
  assign deq_vld_o      = w_deq_fire;
  assign deq_onehot_o   = w_deq_fire ? (C_ONEHOT0 << w_head_idx) : '0;
  assign deq_exc_o      = w_deq_fire & entry_exc_i[w_head_idx];

`ifdef LSU_LSQ_PERF_CNT_EN
  logic [LSQ_PTR_W:0] w_occ;
  logic [31:0]        perf_stall_q;
  logic [31:0]        perf_stall_d;
  logic [LSQ_PTR_W:0] perf_occ_max_q;
  logic [LSQ_PTR_W:0] perf_occ_max_d;

  assign w_occ = w_tail_ptr - w_head_ptr;

  // Saturating stall counter and occupancy high-water mark.
  always_comb begin
    perf_stall_d   = perf_stall_q;
    perf_occ_max_d = perf_occ_max_q;
    if (disp_vld_i && w_full && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (w_occ > perf_occ_max_q) begin
      perf_occ_max_d = w_occ;
    end
  end

  // Perf registers survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q   <= '0;
      perf_occ_max_q <= '0;
    end else begin
      perf_stall_q   <= perf_stall_d;
      perf_occ_max_q <= perf_occ_max_d;
    end
  end

  assign perf_full_stall_o = perf_stall_q;
  assign perf_occ_max_o    = perf_occ_max_q;
`endif

  // The ROB must not commit a head that has not completed.
  a_commit_needs_succ : assert property (
    @(posedge clk) disable iff (rst || flush)
    (rob_commit_i && !w_empty) |-> (entry_vld_i[w_head_idx] && entry_succ_i[w_head_idx])
  ) else $warning("lsq: rob commit before head entry completed");

endmodule

`default_nettype wire

// File: tb/tb_lsu_lsq_alloc_ctrl.sv
// ============================================================================
// Module  : tb_lsu_lsq_alloc_ctrl
// Brief   : Self-checking bench for lsu_lsq_alloc_ctrl (LSQ_DEPTH = 8).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lsu_lsq_alloc_ctrl;

  localparam int D = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         disp_vld_i = 1'b0;
  logic         rob_commit_i = 1'b0;
  logic [D-1:0] entry_vld_i = '0;
  logic [D-1:0] entry_succ_i = '0;
  logic [D-1:0] entry_exc_i = '0;
  logic         disp_rdy_o;
  logic [D-1:0] alloc_onehot_o;
  logic [W-1:0] alloc_idx_o;
  logic [D-1:0] deq_onehot_o;
  logic         deq_vld_o;
  logic         deq_exc_o;
  logic [W-1:0] head_idx_o;
  logic         full_o;
  logic         empty_o;
`ifdef LSU_LSQ_PERF_CNT_EN
  logic [31:0]  perf_full_stall_o;
  logic [W:0]   perf_occ_max_o;
`endif

  lsu_lsq_alloc_ctrl #(.LSQ_DEPTH(D), .LSQ_PTR_W(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .disp_vld_i     (disp_vld_i),
    .disp_rdy_o     (disp_rdy_o),
    .alloc_onehot_o (alloc_onehot_o),
    .alloc_idx_o    (alloc_idx_o),
    .entry_vld_i    (entry_vld_i),
    .entry_succ_i   (entry_succ_i),
    .entry_exc_i    (entry_exc_i),
    .rob_commit_i   (rob_commit_i),
    .deq_onehot_o   (deq_onehot_o),
    .deq_vld_o      (deq_vld_o),
    .deq_exc_o      (deq_exc_o),
    .head_idx_o     (head_idx_o),
    .full_o         (full_o),
    .empty_o        (empty_o)
`ifdef LSU_LSQ_PERF_CNT_EN
    ,
    .perf_full_stall_o (perf_full_stall_o),
    .perf_occ_max_o    (perf_occ_max_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: total ops ever allocated / retired since the last reset or flush.
  int m_alloc_cnt = 0;
  int m_retire_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_fires(output bit a_fire, output bit d_fire);
    int occ;
    int hi;
    occ    = m_alloc_cnt - m_retire_cnt;
    hi     = m_retire_cnt % D;
    a_fire = disp_vld_i && (occ < D) && !flush && !rst;
    d_fire = rob_commit_i && (occ > 0) && entry_vld_i[hi] && entry_succ_i[hi] && !flush && !rst;
  endfunction

  // Advance the model on each clock edge.
  always @(posedge clk) begin
    bit af;
    bit df;
    model_fires(af, df);
    if (rst || flush) begin
      m_alloc_cnt  = 0;
      m_retire_cnt = 0;
    end else begin
      if (af) m_alloc_cnt++;
      if (df) m_retire_cnt++;
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    bit af;
    bit df;
    int occ;
    int hi;
    int ti;
    if (chk_en) begin
      model_fires(af, df);
      occ = m_alloc_cnt - m_retire_cnt;
      hi  = m_retire_cnt % D;
      ti  = m_alloc_cnt % D;
      check("m_disp_rdy", disp_rdy_o, (occ != D));
      check("m_full", full_o, (occ == D));
      check("m_empty", empty_o, (occ == 0));
      check("m_alloc_idx", alloc_idx_o, ti);
      check("m_alloc_onehot", alloc_onehot_o, af ? (64'd1 << ti) : 64'd0);
      check("m_head_idx", head_idx_o, hi);
      check("m_deq_vld", deq_vld_o, df);
      check("m_deq_onehot", deq_onehot_o, df ? (64'd1 << hi) : 64'd0);
      check("m_deq_exc", deq_exc_o, df && entry_exc_i[hi]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst_disp_rdy", disp_rdy_o, 1);
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_alloc_idx", alloc_idx_o, 0);
    check("rst_head_idx", head_idx_o, 0);
    check("rst_deq_vld", deq_vld_o, 0);

    // Fill the queue with 8 consecutive dispatches.
    for (int i = 0; i < D; i++) begin
      cyc();
      disp_vld_i = 1'b1;
      @(negedge clk);
      check("fill_idx", alloc_idx_o, i);
      check("fill_onehot", alloc_onehot_o, 64'd1 << i);
    end
    cyc();
    @(negedge clk);
    check("full_flag", full_o, 1);
    check("full_rdy", disp_rdy_o, 0);
    check("full_no_strobe", alloc_onehot_o, 0);

    // Drain all 8 entries.
    entry_vld_i  = 8'hFF;
    entry_succ_i = 8'hFF;
    for (int i = 0; i < D; i++) begin
      cyc();
      disp_vld_i   = 1'b0;
      rob_commit_i = 1'b1;
      @(negedge clk);
      check("drain_onehot", deq_onehot_o, 64'd1 << i);
      check("drain_vld", deq_vld_o, 1);
    end
    cyc();
    rob_commit_i = 1'b0;
    @(negedge clk);
    check("drain_empty", empty_o, 1);
    check("drain_head_idx", head_idx_o, 0);
    check("drain_head_wrap", dut.w_head_ptr[W], 1);

    // Build occupancy 3, then dispatch+commit together across the wrap.
    for (int i = 0; i < 3; i++) begin
      cyc();
      disp_vld_i = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      cyc();
      disp_vld_i   = 1'b1;
      rob_commit_i = 1'b1;
      @(negedge clk);
      check("steady_full", full_o, 0);
      check("steady_empty", empty_o, 0);
      check("steady_alloc", alloc_onehot_o, 64'd1 << ((11 + i) % D));
      check("steady_deq", deq_onehot_o, 64'd1 << ((8 + i) % D));
    end

    // Commit before completion: head index 4 not yet succeeded.
    cyc();
    disp_vld_i   = 1'b0;
    rob_commit_i = 1'b1;
    entry_succ_i = 8'hEF;
    @(negedge clk);
    check("early_commit_vld", deq_vld_o, 0);
    check("early_commit_head", head_idx_o, 4);
    cyc();
    entry_succ_i = 8'hFF;
    @(negedge clk);
    check("late_commit_vld", deq_vld_o, 1);
    check("late_commit_onehot", deq_onehot_o, 8'h10);

    // Exceptional head retires, then flush.
    cyc();
    entry_exc_i = 8'h20;
    @(negedge clk);
    check("exc_vld", deq_vld_o, 1);
    check("exc_flag", deq_exc_o, 1);
    cyc();
    rob_commit_i = 1'b0;
    entry_exc_i  = 8'h00;
    flush        = 1'b1;
    disp_vld_i   = 1'b1;
    @(negedge clk);
    check("flush_alloc_gate", alloc_onehot_o, 0);
    check("flush_deq_gate", deq_onehot_o, 0);
    cyc();
    flush      = 1'b0;
    disp_vld_i = 1'b0;
    @(negedge clk);
    check("post_flush_empty", empty_o, 1);
    check("post_flush_head", head_idx_o, 0);
    check("post_flush_tail", alloc_idx_o, 0);

`ifdef LSU_LSQ_PERF_CNT_EN
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    disp_vld_i = 1'b1;
    repeat (13) cyc();
    disp_vld_i = 1'b0;
    @(negedge clk);
    check("perf_stall", perf_full_stall_o, 5);
    check("perf_occ_max", perf_occ_max_o, 8);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    check("perf_stall_flush", perf_full_stall_o, 5);
    check("perf_occ_max_flush", perf_occ_max_o, 8);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("perf_stall_rst", perf_full_stall_o, 0);
    check("perf_occ_max_rst", perf_occ_max_o, 0);
`endif

    cyc();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
